sys_ctrl: RTL and testbench

Command sequencer between the UART receive/transmit datapath and the register file / ALU. It consumes bytes from the UART RX path and decodes a four-command frame protocol. It drives register-file writes and reads and ALU operations, gates the ALU clock, and returns results to the UART TX path through the TX FIFO write port.

---
 rtl/sys_ctrl.sv | 169 ++++++++++++++++
 tb/tb_sys_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_ctrl.sv
// Command sequencer: decodes AA/BB/CC/DD frames from the UART RX byte stream into
// register-file writes/reads and ALU operations, and returns results through the TX FIFO.
`timescale 1ns/1ps
module sys_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int FUN_WIDTH  = 4
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
   input  logic                    RX_D_VLD,
   input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
   input  logic                    RF_RD_DATA_VLD,
   input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
   input  logic                    ALU_OUT_VLD,
   input  logic                    FIFO_FULL,
   output logic [ADDR_WIDTH-1:0]   RF_ADDRESS,
   output logic                    RF_WR_EN,
   output logic                    RF_RD_EN,
   output logic [DATA_WIDTH-1:0]   RF_WR_DATA,
   output logic                    ALU_EN,
   output logic [FUN_WIDTH-1:0]    ALU_FUN,
   output logic                    CLK_EN,
   output logic [DATA_WIDTH-1:0]   TX_P_DATA,
   output logic                    TX_D_VLD
);

   typedef enum logic [3:0] {
      IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
      OP_A, OP_B, ALU_FN, ALU_WAIT, TX_LO, TX_HI
   } state_t;

   localparam logic [DATA_WIDTH-1:0] CMD_WR     = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] CMD_RD     = DATA_WIDTH'(8'hBB);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU    = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_ALU_NO = DATA_WIDTH'(8'hDD);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   rd_q, rd_d;
   logic [2*DATA_WIDTH-1:0] res_q, res_d;

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         addr_q  <= '0;
         rd_q    <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         res_q   <= res_d;
      end
   end

   // Every output is zero unless the current state explicitly drives it.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      res_d      = res_q;
      RF_ADDRESS = '0;
      RF_WR_EN   = 1'b0;
      RF_RD_EN   = 1'b0;
      RF_WR_DATA = '0;
      ALU_EN     = 1'b0;
      ALU_FUN    = '0;
      CLK_EN     = 1'b0;
      TX_P_DATA  = '0;
      TX_D_VLD   = 1'b0;
      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               case (RX_P_DATA)
                  CMD_WR:     state_d = WR_ADDR;
                  CMD_RD:     state_d = RD_ADDR;
                  CMD_ALU:    state_d = OP_A;
                  CMD_ALU_NO: state_d = ALU_FN;
                  default:    state_d = IDLE;
               endcase
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               RF_WR_EN   = 1'b1;
               RF_ADDRESS = addr_q;
               RF_WR_DATA = RX_P_DATA;
               state_d    = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               RF_RD_EN   = 1'b1;
               RF_ADDRESS = RX_P_DATA[ADDR_WIDTH-1:0];
               state_d    = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (RF_RD_DATA_VLD) begin
               rd_d    = RF_RD_DATA;
               state_d = TX_RD;
            end
         end
         TX_RD: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = rd_q;
               state_d   = IDLE;
            end
         end
         // Operands land in the two fixed ALU source registers, 0 then 1.
         OP_A: begin
            if (RX_D_VLD) begin
               RF_WR_EN   = 1'b1;
               RF_ADDRESS = '0;
               RF_WR_DATA = RX_P_DATA;
               state_d    = OP_B;
            end
         end
         OP_B: begin
            if (RX_D_VLD) begin
               RF_WR_EN   = 1'b1;
               RF_ADDRESS = ADDR_WIDTH'(1);
               RF_WR_DATA = RX_P_DATA;
               state_d    = ALU_FN;
            end
         end
         ALU_FN: begin
            CLK_EN = 1'b1;
            if (RX_D_VLD) begin
               ALU_EN  = 1'b1;
               ALU_FUN = RX_P_DATA[FUN_WIDTH-1:0];
               state_d = ALU_WAIT;
            end
         end
         ALU_WAIT: begin
            CLK_EN = 1'b1;
            if (ALU_OUT_VLD) begin
               res_d   = ALU_OUT;
               state_d = TX_LO;
            end
         end
         TX_LO: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = res_q[DATA_WIDTH-1:0];
               state_d   = TX_HI;
            end
         end
         TX_HI: begin
            if (!FIFO_FULL) begin
               TX_D_VLD  = 1'b1;
               TX_P_DATA = res_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sys_ctrl.sv
// Bench for sys_ctrl: frame-level driver tasks push the cycle-exact expected output word
// derived from the command protocol; every cycle the full output vector is compared.
`timescale 1ns/1ps
module tb_sys_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic [7:0]  RX_P_DATA;
   logic        RX_D_VLD;
   logic [7:0]  RF_RD_DATA;
   logic        RF_RD_DATA_VLD;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VLD;
   logic        FIFO_FULL;
   logic [3:0]  RF_ADDRESS;
   logic        RF_WR_EN;
   logic        RF_RD_EN;
   logic [7:0]  RF_WR_DATA;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic        CLK_EN;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;

   sys_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FUN_WIDTH(4)) dut (
      .CLK(CLK), .RST(RST),
      .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .RF_RD_DATA(RF_RD_DATA), .RF_RD_DATA_VLD(RF_RD_DATA_VLD),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .FIFO_FULL(FIFO_FULL),
      .RF_ADDRESS(RF_ADDRESS), .RF_WR_EN(RF_WR_EN), .RF_RD_EN(RF_RD_EN),
      .RF_WR_DATA(RF_WR_DATA), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
      .CLK_EN(CLK_EN), .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
   );

   always #5 CLK = ~CLK;

   // Output word: {CLK_EN, WR_EN, RD_EN, ALU_EN, TX_VLD, ADDR, FUN, WR_DATA, TX_DATA}
   localparam int W = 29;
   logic [W-1:0] exp_q[$];
   logic         exp_clk_en;
   logic [7:0]   rf_model[16];
   int           n_cmp  = 0;
   int           n_fail = 0;

   function automatic logic [W-1:0] ev(input logic wr, input logic rd, input logic alu,
                                       input logic tx, input logic [3:0] a, input logic [3:0] f,
                                       input logic [7:0] wd, input logic [7:0] td);
      return {1'b0, wr, rd, alu, tx, a, f, wd, td};
   endfunction

   // Inputs are set #1 after a rising edge; outputs are sampled on the falling edge.
   task automatic cyc(input string tag);
      logic [W-1:0] e_w, o_w;
      @(negedge CLK);
      e_w = '0;
      if (exp_q.size() != 0) e_w = exp_q.pop_front();
      e_w[W-1] = exp_clk_en;
      o_w = {CLK_EN, RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD,
             RF_ADDRESS, ALU_FUN, RF_WR_DATA, TX_P_DATA};
      n_cmp++;
      assert (o_w === e_w) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, o_w, e_w);
      end
      exp_q.delete();
      @(posedge CLK);
      #1;
      RX_D_VLD       = 1'b0;
      RF_RD_DATA_VLD = 1'b0;
      ALU_OUT_VLD    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic has_e, input logic [W-1:0] e,
                       input string tag);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      if (has_e) exp_q.push_back(e);
      cyc(tag);
   endtask

   // A cycle in which nothing should happen, optionally with noise the DUT must ignore.
   task automatic quiet(input logic noise, input string tag);
      if (noise) begin
         RX_P_DATA = 8'($urandom);
         RX_D_VLD  = 1'($urandom);
         ALU_OUT   = 16'($urandom);
      end
      cyc(tag);
   endtask

   task automatic stall_tx(input int n, input logic noise, input string tag);
      if (n > 0) begin
         FIFO_FULL = 1'b1;
         repeat (n) quiet(noise, tag);
         FIFO_FULL = 1'b0;
      end
   endtask

   task automatic do_write(input logic [7:0] a, input logic [7:0] d);
      send(8'hAA, 1'b0, '0, "wr_cmd");
      send(a, 1'b0, '0, "wr_addr");
      send(d, 1'b1, ev(1, 0, 0, 0, a[3:0], 4'h0, d, 8'h00), "wr_data");
      rf_model[a[3:0]] = d;
   endtask

   task automatic do_read(input logic [7:0] a, input int lat, input int stall, input logic noise);
      send(8'hBB, 1'b0, '0, "rd_cmd");
      send(a, 1'b1, ev(0, 1, 0, 0, a[3:0], 4'h0, 8'h00, 8'h00), "rd_addr");
      repeat (lat) quiet(noise, "rd_wait");
      RF_RD_DATA     = rf_model[a[3:0]];
      RF_RD_DATA_VLD = 1'b1;
      cyc("rd_vld");
      RF_RD_DATA = 8'($urandom);
      stall_tx(stall, noise, "rd_stall");
      exp_q.push_back(ev(0, 0, 0, 1, 4'h0, 4'h0, 8'h00, rf_model[a[3:0]]));
      cyc("rd_tx");
   endtask

   task automatic do_alu(input logic with_ops, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] f, input logic [15:0] res, input int gap,
                         input int lat, input int stall_lo, input int stall_hi, input logic noise);
      if (with_ops) begin
         send(8'hCC, 1'b0, '0, "alu_cmd");
         send(a, 1'b1, ev(1, 0, 0, 0, 4'h0, 4'h0, a, 8'h00), "op_a");
         rf_model[0] = a;
         send(b, 1'b1, ev(1, 0, 0, 0, 4'h1, 4'h0, b, 8'h00), "op_b");
         rf_model[1] = b;
      end else begin
         send(8'hDD, 1'b0, '0, "alu_cmd_no");
      end
      exp_clk_en = 1'b1;
      repeat (gap) quiet(1'b0, "alu_fn_idle");
      send(f, 1'b1, ev(0, 0, 1, 0, 4'h0, f[3:0], 8'h00, 8'h00), "alu_fn");
      repeat (lat) quiet(noise, "alu_wait");
      ALU_OUT     = res;
      ALU_OUT_VLD = 1'b1;
      cyc("alu_vld");
      exp_clk_en = 1'b0;
      ALU_OUT    = 16'($urandom);
      stall_tx(stall_lo, noise, "lo_stall");
      exp_q.push_back(ev(0, 0, 0, 1, 4'h0, 4'h0, 8'h00, res[7:0]));
      cyc("tx_lo");
      stall_tx(stall_hi, noise, "hi_stall");
      exp_q.push_back(ev(0, 0, 0, 1, 4'h0, 4'h0, 8'h00, res[15:8]));
      cyc("tx_hi");
   endtask

   task automatic do_junk();
      logic [7:0] b;
      b = 8'($urandom);
      while (b == 8'hAA || b == 8'hBB || b == 8'hCC || b == 8'hDD) b = 8'($urandom);
      RF_RD_DATA_VLD = 1'($urandom);
      ALU_OUT_VLD    = 1'($urandom);
      send(b, 1'b0, '0, "junk_idle");
   endtask

   initial begin
      RST            = 1'b0;
      RX_P_DATA      = '0;
      RX_D_VLD       = 1'b0;
      RF_RD_DATA     = '0;
      RF_RD_DATA_VLD = 1'b0;
      ALU_OUT        = '0;
      ALU_OUT_VLD    = 1'b0;
      FIFO_FULL      = 1'b0;
      exp_clk_en     = 1'b0;
      for (int i = 0; i < 16; i++) rf_model[i] = 8'($urandom);

      cyc("reset");
      RX_P_DATA = 8'hAA;
      RX_D_VLD  = 1'b1;
      cyc("reset_rx");
      RST = 1'b1;
      cyc("post_reset");

      // Directed frames
      do_write(8'h05, 8'h3C);
      do_read(8'h05, 0, 0, 1'b0);
      do_alu(1'b1, 8'h0A, 8'h03, 8'h00, 16'h000D, 0, 1, 0, 0, 1'b0);
      do_alu(1'b0, 8'h00, 8'h00, 8'h02, 16'h1234, 0, 1, 5, 0, 1'b0);
      send(8'h55, 1'b0, '0, "unknown_byte");
      quiet(1'b0, "unknown_after");
      do_read(8'hF5, 2, 1, 1'b1);
      do_write(8'hFE, 8'hA5);
      do_read(8'h0E, 1, 0, 1'b0);

      // Reset in the middle of an ALU wait aborts the frame
      send(8'hDD, 1'b0, '0, "rst_cmd");
      exp_clk_en = 1'b1;
      send(8'h37, 1'b1, ev(0, 0, 1, 0, 4'h0, 4'h7, 8'h00, 8'h00), "rst_fn");
      quiet(1'b0, "rst_wait");
      RST        = 1'b0;
      exp_clk_en = 1'b0;
      #1;
      n_cmp++;
      assert ({CLK_EN, RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD} === 5'b0) else begin
         n_fail++;
         $error("FAIL rst_immediate observed=%b expected=%b",
                {CLK_EN, RF_WR_EN, RF_RD_EN, ALU_EN, TX_D_VLD}, 5'b0);
      end
      cyc("rst_mid");
      RST         = 1'b1;
      ALU_OUT     = 16'hBEEF;
      ALU_OUT_VLD = 1'b1;
      cyc("rst_stale_vld");
      quiet(1'b0, "rst_idle");
      do_write(8'h09, 8'h96);
      do_read(8'h09, 0, 0, 1'b0);

      // Randomized frame mix
      for (int k = 0; k < 120; k++) begin
         case ($urandom_range(0, 4))
            0: do_write(8'($urandom), 8'($urandom));
            1: do_read(8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
            2: do_alu(1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 16'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'($urandom));
            3: do_alu(1'b0, 8'h00, 8'h00, 8'($urandom), 16'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2), 1'($urandom));
            default: do_junk();
         endcase
      end
      quiet(1'b0, "final_idle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
